// File: rtl/usb_conv_pkg.sv
// Shared types and constants for the FX2 slave-FIFO convolution bridge.
// No logic of its own; state encoding, endpoint addresses, kernel indices.
// Counter width helper sizes packet counters so they can hold DEPTH itself.
package usb_conv_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEL_RD = 3'd1,
    READ   = 3'd2,
    SEL_WR = 3'd3,
    WRITE  = 3'd4,
    PKTEND = 3'd5
  } state_t;

  localparam logic [1:0] EP_RD_ADDR = 2'b00;
  localparam logic [1:0] EP_WR_ADDR = 2'b10;

  // Kernel selectors, in the order they are emitted for each window.
  localparam logic [1:0] K_EVEN   = 2'd0;
  localparam logic [1:0] K_VERT   = 2'd1;
  localparam logic [1:0] K_HORZ   = 2'd2;
  localparam logic [1:0] K_CENTER = 2'd3;

  // Bits needed for a counter that runs 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/usb_conv_if.sv
// FX2 slave-FIFO control pins (flags, FIFOADR, strobes) as one bundle.
// master = FPGA bridge side, slave = FX2 side; all strobes active-low.
// The tristate data bus stays a plain inout port on the bridge.
interface usb_conv_if;
  logic       flaga;
  logic       flagd;
  logic [1:0] addr;
  logic       slrd;
  logic       slwr;
  logic       sloe;
  logic       pkend;

  modport master (input flaga, flagd, output addr, slrd, slwr, sloe, pkend);
  modport slave  (output flaga, flagd, input addr, slrd, slwr, sloe, pkend);
endinterface

// File: rtl/usb_conv_kernel.sv
// 9-tap kernel evaluator: adder tree selected by kernel index, registered result.
// Latency: one clock from ld to res.
// No backpressure; ld is issued by the bridge only when the result is wanted.
// USB_CONV_SAT_EN: clamp to [0, 2^DATA_WIDTH-1]; otherwise two's-complement wrap.
module usb_conv_kernel
  import usb_conv_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ld,
  input  logic [1:0]                 kidx,
  input  logic [8:0][DATA_WIDTH-1:0] taps,
  output logic [DATA_WIDTH-1:0]      res
);

  localparam int AW = DATA_WIDTH + 4;
`ifdef USB_CONV_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  function automatic logic signed [AW-1:0] ext(input logic [DATA_WIDTH-1:0] v);
    return signed'({4'b0000, v});
  endfunction

  logic signed [AW-1:0]  acc;
  logic [DATA_WIDTH-1:0] res_d;

  // Signed accumulation of the selected kernel, then clamp or wrap.
  always_comb begin
    case (kidx)
      K_EVEN:  acc = ext(taps[0]) + ext(taps[2]) + ext(taps[4]) + ext(taps[6]) + ext(taps[8]);
      K_VERT:  acc = ext(taps[0]) + ext(taps[1]) + ext(taps[2])
                   - ext(taps[6]) - ext(taps[7]) - ext(taps[8]);
      K_HORZ:  acc = ext(taps[0]) - ext(taps[2]) + ext(taps[3])
                   - ext(taps[5]) + ext(taps[6]) - ext(taps[8]);
      default: acc = ext(taps[4]);
    endcase
    res_d = acc[DATA_WIDTH-1:0];
    if (SAT_EN && acc[AW-1]) begin
      res_d = '0;
    end else if (SAT_EN && (|acc[AW-2:DATA_WIDTH])) begin
      res_d = '1;
    end
  end

  // Output register: result is held on the bus through setup and strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      res <= '0;
    end else if (ld) begin
      res <= res_d;
    end
  end

endmodule

// File: rtl/usb_conv_bridge.sv
// FX2 slave-FIFO bridge: reads a packet from EP2, returns 3x3-kernel results or loopback to EP6.
// Latency: 2 clocks per word read and per word written; result registered one cycle before setup.
// Backpressure: flagd low holds the current word in setup (no strobe), resuming when flagd returns.
// Build option: USB_CONV_SAT_EN selects saturating kernel results (default is wrap).
module usb_conv_bridge
  import usb_conv_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 512,
  parameter int N_KERNELS  = 4,
  parameter int STRIDE     = 3
) (
  input  logic                  i_usb_ifclk,
  input  logic                  i_rst,
  input  logic                  i_mode,
  usb_conv_if.master            usb,
  inout  wire [DATA_WIDTH-1:0]  io_usb_data,
  output logic                  o_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam int PW = CW + 1;

  state_t                       state;
  logic                         mode_q;
  logic [CW-1:0]                cnt;
  logic [PW-1:0]                pos;
  logic [1:0]                   kx;
  logic                         stb;
  logic                         more;
  logic                         bus_oe;
  logic [DATA_WIDTH-1:0]        mem [DEPTH];
  logic [8:0][DATA_WIDTH-1:0]   taps;
  logic [DATA_WIDTH-1:0]        k_res;
  logic [DATA_WIDTH-1:0]        lb_dat;
  logic                         ld;
  logic                         rd_take;
  logic                         rd_done;
  logic                         rd_empty;
  logic [CW-1:0]                cnt_nx;
  logic [PW-1:0]                pos_nx;
  logic [1:0]                   k_nx;
  logic                         more_nx;

  assign rd_take  = (state == READ) && !usb.slrd && usb.flaga;
  assign cnt_nx   = cnt + CW'(rd_take);
  assign rd_done  = !usb.flaga || (cnt_nx == CW'(DEPTH));
  assign rd_empty = mode_q ? (cnt_nx == '0) : (cnt_nx < CW'(9));
  assign ld       = (state == SEL_WR) || ((state == WRITE) && stb && more);

  assign io_usb_data = bus_oe ? (mode_q ? lb_dat : k_res) : 'z;

  // Window taps x0..x8 start at the current output position.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      taps[i] = mem[pos[AW-1:0] + AW'(i)];
    end
  end

  // Position of the following output word and whether it exists.
  always_comb begin
    pos_nx = pos;
    k_nx   = '0;
    if (mode_q) begin
      pos_nx  = pos + PW'(1);
      more_nx = pos_nx < {1'b0, cnt};
    end else begin
      if (kx == 2'(N_KERNELS - 1)) begin
        pos_nx = pos + PW'(STRIDE);
      end else begin
        k_nx = kx + 2'd1;
      end
      more_nx = (pos_nx + PW'(8)) < {1'b0, cnt};
    end
  end

  // Packet buffer; contents are don't-care outside a packet.
  always_ff @(posedge i_usb_ifclk) begin
    if (rd_take) begin
      mem[cnt[AW-1:0]] <= io_usb_data;
    end
  end

  // Loopback word register, loaded alongside the kernel result.
  always_ff @(posedge i_usb_ifclk) begin
    if (i_rst) begin
      lb_dat <= '0;
    end else if (ld) begin
      lb_dat <= taps[0];
    end
  end

  usb_conv_kernel #(.DATA_WIDTH(DATA_WIDTH)) u_kernel (
    .clk  (i_usb_ifclk),
    .rst  (i_rst),
    .ld   (ld),
    .kidx (kx),
    .taps (taps),
    .res  (k_res)
  );

  // Control FSM with registered FX2 strobes, address and bus enable.
  always_ff @(posedge i_usb_ifclk) begin
    if (i_rst) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      cnt       <= '0;
      pos       <= '0;
      kx        <= '0;
      stb       <= 1'b0;
      more      <= 1'b0;
      bus_oe    <= 1'b0;
      o_busy    <= 1'b0;
      usb.addr  <= EP_RD_ADDR;
      usb.slrd  <= 1'b1;
      usb.slwr  <= 1'b1;
      usb.sloe  <= 1'b1;
      usb.pkend <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          mode_q <= i_mode;
          cnt    <= '0;
          pos    <= '0;
          kx     <= '0;
          stb    <= 1'b0;
          if (usb.flaga) begin
            state    <= SEL_RD;
            usb.addr <= EP_RD_ADDR;
            usb.sloe <= 1'b0;
            o_busy   <= 1'b1;
          end
        end
        SEL_RD: begin
          state    <= READ;
          usb.slrd <= 1'b1;
        end
        READ: begin
          cnt <= cnt_nx;
          if (rd_done) begin
            usb.slrd <= 1'b1;
            usb.sloe <= 1'b1;
            pos      <= '0;
            kx       <= '0;
            if (rd_empty) begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end else begin
              state    <= SEL_WR;
              usb.addr <= EP_WR_ADDR;
              bus_oe   <= 1'b1;
            end
          end else begin
            usb.slrd <= ~usb.slrd;
          end
        end
        SEL_WR: begin
          state <= WRITE;
          stb   <= 1'b0;
          more  <= 1'b1;
        end
        WRITE: begin
          if (!stb) begin
            if (usb.flagd) begin
              usb.slwr <= 1'b0;
              stb      <= 1'b1;
              pos      <= pos_nx;
              kx       <= k_nx;
              more     <= more_nx;
            end
          end else begin
            usb.slwr <= 1'b1;
            stb      <= 1'b0;
            if (!more) begin
              state     <= PKTEND;
              usb.pkend <= 1'b0;
            end
          end
        end
        PKTEND: begin
          state     <= IDLE;
          usb.pkend <= 1'b1;
          usb.addr  <= EP_RD_ADDR;
          bus_oe    <= 1'b0;
          o_busy    <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_conv_bridge.sv
// Bench for usb_conv_bridge: FX2 endpoint model plus packet-level reference model.
// DEPTH=16 so the 20-word ramp also exercises the buffer-full split.
// Honours USB_CONV_SAT_EN the same way as the RTL.
module tb_usb_conv_bridge;

  localparam int W      = 16;
  localparam int DEPTH  = 16;
  localparam int NK     = 4;
  localparam int STRIDE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          mode;
  logic          busy;
  wire  [W-1:0]  usb_data;
  logic [W-1:0]  ep2_head;

  usb_conv_if u_if ();

  // FX2 drives EP2 data whenever the bridge enables its output on EP2.
  assign usb_data = (!u_if.sloe && u_if.addr == 2'b00) ? ep2_head : 'z;

  usb_conv_bridge #(
    .DATA_WIDTH (W),
    .DEPTH      (DEPTH),
    .N_KERNELS  (NK),
    .STRIDE     (STRIDE)
  ) dut (
    .i_usb_ifclk (clk),
    .i_rst       (rst),
    .i_mode      (mode),
    .usb         (u_if),
    .io_usb_data (usb_data),
    .o_busy      (busy)
  );

  logic [W-1:0] ep2_q[$];
  logic [W-1:0] ep6_q[$];
  logic [W-1:0] stim_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp4[4];
  int pkend_cnt, exp_pk, stall_at, stall_left, n_chk, n_err;
  bit pend_pop, flagd_rand;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_kernel(input int x[9], input int k);
    int s;
    case (k)
      0:       s = x[0] + x[2] + x[4] + x[6] + x[8];
      1:       s = x[0] + x[1] + x[2] - x[6] - x[7] - x[8];
      2:       s = x[0] - x[2] + x[3] - x[5] + x[6] - x[8];
      default: s = x[4];
    endcase
`ifdef USB_CONV_SAT_EN
    if (s < 0) s = 0;
    if (s > (1 << W) - 1) s = (1 << W) - 1;
`endif
    return s[W-1:0];
  endfunction

  // Expected EP6 stream: split queued words into DEPTH-sized packets, reply per packet.
  task automatic build_expect(input bit lb);
    int base, n, w;
    int x[9];
    exp_q.delete();
    exp_pk = 0;
    base = 0;
    while (base < stim_q.size()) begin
      n = stim_q.size() - base;
      if (n > DEPTH) n = DEPTH;
      if (lb) begin
        for (int i = 0; i < n; i++) exp_q.push_back(stim_q[base + i]);
        exp_pk++;
      end else begin
        w = 0;
        for (int b = 0; b + 8 < n; b += STRIDE) begin
          for (int j = 0; j < 9; j++) x[j] = int'(stim_q[base + b + j]);
          for (int k = 0; k < NK; k++) exp_q.push_back(ref_kernel(x, k));
          w++;
        end
        if (w > 0) exp_pk++;
      end
      base += n;
    end
  endtask

  // One clock of the FX2 model, evaluated at the falling edge.
  task automatic tick();
    @(negedge clk);
    if (pend_pop && ep2_q.size() > 0) void'(ep2_q.pop_front());
    pend_pop = 1'b0;
    if (!u_if.slwr) begin
      ep6_q.push_back(usb_data);
      if (ep6_q.size() == stall_at) stall_left = 10;
    end
    if (!u_if.pkend) pkend_cnt++;
    u_if.flaga = (ep2_q.size() > 0);
    ep2_head   = (ep2_q.size() > 0) ? ep2_q[0] : '0;
    if (stall_left > 0) begin
      u_if.flagd = 1'b0;
      stall_left--;
    end else begin
      u_if.flagd = flagd_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    if (!u_if.slrd && u_if.flaga) pend_pop = 1'b1;
  endtask

  task automatic run_case(input string tag, input bit lb, input bit rnd, input int stall);
    int cyc, idle;
    mode       = lb;
    flagd_rand = rnd;
    stall_at   = stall;
    stall_left = 0;
    build_expect(lb);
    ep6_q.delete();
    pkend_cnt = 0;
    ep2_q = stim_q;
    cyc  = 0;
    idle = 0;
    while (idle < 4 && cyc < 3000) begin
      tick();
      cyc++;
      if (ep2_q.size() == 0 && !busy) idle++;
      else idle = 0;
    end
    check_eq({tag, " finished"}, 32'(cyc < 3000), 32'd1);
    check_eq({tag, " n_out"}, ep6_q.size(), exp_q.size());
    check_eq({tag, " pkend"}, pkend_cnt, exp_pk);
    check_eq({tag, " ep2_left"}, ep2_q.size(), 0);
    for (int i = 0; i < exp_q.size() && i < ep6_q.size(); i++)
      check_eq($sformatf("%s w%0d", tag, i), ep6_q[i], exp_q[i]);
  endtask

  task automatic check_idle_pins(input string tag);
    check_eq({tag, " strobes"}, {u_if.slrd, u_if.slwr, u_if.sloe, u_if.pkend}, 4'hF);
    check_eq({tag, " addr"}, u_if.addr, 2'b00);
    check_eq({tag, " busy"}, busy, 1'b0);
    check_eq({tag, " bus_drive"}, dut.bus_oe, 1'b0);
  endtask

  task automatic reset_when(input string tag, input bit on_write);
    int cyc;
    stim_q.delete();
    for (int i = 0; i < 12; i++) stim_q.push_back(W'($urandom));
    mode = 1'b1;
    flagd_rand = 1'b0;
    stall_at = -1;
    ep2_q = stim_q;
    cyc = 0;
    while (cyc < 200 && !(on_write ? !u_if.slwr : !u_if.slrd)) begin
      tick();
      cyc++;
    end
    check_eq({tag, " reached"}, 32'(cyc < 200), 32'd1);
    tick();
    rst = 1'b1;
    ep2_q.delete();
    tick();
    check_idle_pins(tag);
    rst = 1'b0;
    pend_pop = 1'b0;
    tick();
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    rst = 1'b1; mode = 1'b0; ep2_head = '0;
    u_if.flaga = 1'b0; u_if.flagd = 1'b1;
    pend_pop = 1'b0; flagd_rand = 1'b0; stall_at = -1; stall_left = 0; pkend_cnt = 0;
    repeat (3) tick();
    check_idle_pins("reset");
    rst = 1'b0;
    tick();

    // Compute on 1..9 with literal expected values.
    stim_q.delete();
    for (int i = 1; i <= 9; i++) stim_q.push_back(W'(i));
    run_case("cmp9", 1'b0, 1'b0, -1);
`ifdef USB_CONV_SAT_EN
    exp4 = '{16'd25, 16'd0, 16'd0, 16'd5};
`else
    exp4 = '{16'd25, 16'hFFEE, 16'hFFFA, 16'd5};
`endif
    for (int i = 0; i < 4 && i < ep6_q.size(); i++)
      check_eq($sformatf("cmp9 lit%0d", i), ep6_q[i], exp4[i]);

    // 20-word ramp in loopback: two packets (16 + 4) through a 16-deep buffer.
    stim_q.delete();
    for (int i = 0; i < 20; i++) stim_q.push_back(W'(16'h0100 + i));
    run_case("lb_ramp", 1'b1, 1'b0, -1);
    check_eq("lb_ramp count", ep6_q.size(), 20);

    // Compute on 8 words: nothing written, no pkend.
    stim_q.delete();
    for (int i = 0; i < 8; i++) stim_q.push_back(W'($urandom));
    run_case("cmp8", 1'b0, 1'b0, -1);
    check_eq("cmp8 none", ep6_q.size() + pkend_cnt, 0);

    // 15 words, flagd held low 10 cycles after the 2nd output.
    stim_q.delete();
    for (int i = 0; i < 15; i++) stim_q.push_back(W'($urandom));
    run_case("stall15", 1'b0, 1'b0, 2);
    check_eq("stall15 count", ep6_q.size(), 12);

    // Randomized lengths, modes, data and EP6 backpressure.
    for (int t = 0; t < 10; t++) begin
      stim_q.delete();
      for (int i = 0; i < int'($urandom_range(1, 24)); i++) stim_q.push_back(W'($urandom));
      run_case($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), 1'b1, -1);
    end

    reset_when("rst_read", 1'b0);
    reset_when("rst_write", 1'b1);

    // Normal operation after the abandoned packets.
    stim_q.delete();
    for (int i = 0; i < 10; i++) stim_q.push_back(W'($urandom));
    run_case("recover", 1'b0, 1'b1, -1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
